// File: rtl/dsec_key_loader.sv
// Key-load and data-routing controller: loads NUM_KEYS key words, then forwards the stream through a 1-deep buffer.
// Optional per-byte odd-parity key check enabled by defining DSEC_KEY_PARITY_EN.
module dsec_key_loader #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_KEYS = 3,
  localparam int unsigned CNT_W   = $clog2(NUM_KEYS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         key_config,
  input  logic                         in_valid,
  output logic                         rdy,
  output logic [DATA_W-1:0]            comp_data,
  output logic                         comp_valid,
  input  logic                         comp_ready,
  output logic [NUM_KEYS*DATA_W-1:0]   key_out,
  output logic                         keys_valid,
  output logic [CNT_W-1:0]             key_count,
  output logic                         done,
  output logic                         error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t                       r_state;
  logic [NUM_KEYS*DATA_W-1:0]   r_key;
  logic [CNT_W-1:0]             r_key_count;
  logic                         r_keys_valid;
  logic                         r_done;
  logic                         r_error;
  logic [DATA_W-1:0]            r_comp_data;
  logic                         r_comp_valid;

  logic                         w_rdy;
  logic                         w_xfer;
  logic                         w_par_ok;

  // rdy follows comp_ready combinationally in RUN so accept+drain sustains one word per cycle
  always_comb begin
    w_rdy = 1'b0;
    if (r_state == S_LOAD)
      w_rdy = 1'b1;
    else if (r_state == S_RUN)
      w_rdy = !r_comp_valid || comp_ready;
  end

  assign w_xfer = in_valid && w_rdy;

`ifdef DSEC_KEY_PARITY_EN
  always_comb begin
    w_par_ok = 1'b1;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      if (!(^data_in[b*8 +: 8]))
        w_par_ok = 1'b0;
    end
  end
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_key_count  <= '0;
      r_keys_valid <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_comp_data  <= '0;
      r_comp_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (key_config) begin
            r_state      <= S_LOAD;
            r_key        <= '0;
            r_key_count  <= '0;
            r_keys_valid <= 1'b0;
          end else if (in_valid) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end
        end

        S_LOAD: begin
          // a restart swallows any word presented in the same cycle
          if (key_config) begin
            r_key       <= '0;
            r_key_count <= '0;
          end else if (w_xfer) begin
            if (!w_par_ok) begin
              r_state     <= S_ERR;
              r_error     <= 1'b1;
              r_key       <= '0;
              r_key_count <= '0;
            end else begin
              for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (r_key_count == CNT_W'(i))
                  r_key[i*DATA_W +: DATA_W] <= data_in;
              end
              r_key_count <= r_key_count + CNT_W'(1);
              if (r_key_count == CNT_W'(NUM_KEYS - 1)) begin
                r_done       <= 1'b1;
                r_keys_valid <= 1'b1;
                r_state      <= S_RUN;
              end
            end
          end
        end

        S_RUN: begin
          if (w_xfer) begin
            r_comp_data  <= data_in;
            r_comp_valid <= 1'b1;
          end else if (comp_ready) begin
            r_comp_valid <= 1'b0;
          end
          if (key_config)
            r_state <= S_DRAIN;
        end

        S_DRAIN: begin
          if (!r_comp_valid || comp_ready) begin
            r_comp_valid <= 1'b0;
            r_state      <= S_LOAD;
            r_key        <= '0;
            r_key_count  <= '0;
            r_keys_valid <= 1'b0;
          end
        end

        S_ERR: begin
          r_comp_valid <= 1'b0;
          if (key_config) begin
            r_state      <= S_LOAD;
            r_error      <= 1'b0;
            r_key        <= '0;
            r_key_count  <= '0;
            r_keys_valid <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdy        = w_rdy;
  assign comp_data  = r_comp_data;
  assign comp_valid = r_comp_valid;
  assign key_out    = r_key;
  assign keys_valid = r_keys_valid;
  assign key_count  = r_key_count;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_dsec_key_loader.sv
// Directed self-checking bench for dsec_key_loader; inputs driven and outputs sampled on the falling edge.
module tb_dsec_key_loader;

  localparam logic [63:0] K0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K1 = 64'hFEDCBA9876543210;
`ifdef DSEC_KEY_PARITY_EN
  localparam logic [63:0] K2 = 64'h0101010101010101;
`else
  localparam logic [63:0] K2 = 64'h1111111111111111;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   data_in = '0;
  logic          key_config = 1'b0;
  logic          in_valid = 1'b0;
  logic          comp_ready = 1'b0;
  logic          rdy;
  logic [63:0]   comp_data;
  logic          comp_valid;
  logic [191:0]  key_out;
  logic          keys_valid;
  logic [1:0]    key_count;
  logic          done;
  logic          error;

  int errors = 0;
  int checks = 0;

  dsec_key_loader #(.DATA_W(64), .NUM_KEYS(3)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .key_config(key_config),
    .in_valid(in_valid), .rdy(rdy), .comp_data(comp_data), .comp_valid(comp_valid),
    .comp_ready(comp_ready), .key_out(key_out), .keys_valid(keys_valid),
    .key_count(key_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; key_config = 1'b0; in_valid = 1'b0; comp_ready = 1'b0; data_in = '0;
    tick;
    rst = 1'b0;
  endtask

  // Starts at a falling edge in IDLE/ERR; returns at the falling edge where done is visible.
  task automatic load_keys(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    key_config = 1'b1; tick;
    key_config = 1'b0; in_valid = 1'b1; data_in = a; tick;
    data_in = b; tick;
    data_in = c; tick;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++; if ({keys_valid, key_count, done, error, rdy, comp_valid} !== 7'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0", {keys_valid, key_count, done, error, rdy, comp_valid}); end
    checks++; if (key_out !== 192'b0) begin errors++; $display("FAIL reset_key_out got=%h exp=0", key_out); end
    checks++; if (comp_data !== 64'b0) begin errors++; $display("FAIL reset_comp_data got=%h exp=0", comp_data); end
    rst = 1'b0;
    tick;
    checks++; if ({rdy, error} !== 2'b00) begin errors++; $display("FAIL idle_rdy_err got=%b exp=00", {rdy, error}); end
  endtask

  task automatic test_load;
    key_config = 1'b1; tick;
    checks++; if ({rdy, keys_valid, key_count} !== 4'b1000) begin errors++; $display("FAIL load_entry got=%b exp=1000", {rdy, keys_valid, key_count}); end
    key_config = 1'b0; in_valid = 1'b1; data_in = K0; tick;
    checks++; if (key_count !== 2'd1) begin errors++; $display("FAIL load_cnt1 got=%0d exp=1", key_count); end
    data_in = K1; tick;
    checks++; if ({key_count, done} !== 3'b100) begin errors++; $display("FAIL load_cnt2 got=%b exp=100", {key_count, done}); end
    data_in = K2; tick;
    in_valid = 1'b0;
    checks++; if ({done, keys_valid, key_count} !== 4'b1111) begin errors++; $display("FAIL load_done got=%b exp=1111", {done, keys_valid, key_count}); end
    checks++; if (key_out !== {K2, K1, K0}) begin errors++; $display("FAIL load_keys got=%h exp=%h", key_out, {K2, K1, K0}); end
    tick;
    checks++; if ({done, key_count} !== 3'b011) begin errors++; $display("FAIL done_pulse got=%b exp=011", {done, key_count}); end
  endtask

  task automatic test_stream;
    comp_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin
        checks++; if (comp_valid !== 1'b1 || comp_data !== 64'(i - 1)) begin errors++; $display("FAIL stream_word%0d got=%b/%h exp=1/%h", i - 1, comp_valid, comp_data, 64'(i - 1)); end
      end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy%0d got=%b exp=1", i, rdy); end
      if (i <= 8) begin in_valid = 1'b1; data_in = 64'(i); end
      else in_valid = 1'b0;
      tick;
    end
    checks++; if (comp_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got=%b exp=0", comp_valid); end
  endtask

  task automatic test_backpressure;
    comp_ready = 1'b0; in_valid = 1'b1; data_in = 64'hAA; tick;
    checks++; if ({comp_valid, rdy} !== 2'b10 || comp_data !== 64'hAA) begin errors++; $display("FAIL bp_hold0 got=%b/%h exp=10/aa", {comp_valid, rdy}, comp_data); end
    data_in = 64'hBB; tick; tick;
    checks++; if ({comp_valid, rdy} !== 2'b10 || comp_data !== 64'hAA) begin errors++; $display("FAIL bp_hold2 got=%b/%h exp=10/aa", {comp_valid, rdy}, comp_data); end
    in_valid = 1'b0; comp_ready = 1'b1; #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_release got=%b exp=1", rdy); end
    tick;
    checks++; if (comp_valid !== 1'b0 || comp_data !== 64'hAA) begin errors++; $display("FAIL bp_once got=%b/%h exp=0/aa", comp_valid, comp_data); end
  endtask

  task automatic test_rekey;
    comp_ready = 1'b0; in_valid = 1'b1; data_in = 64'hCC; tick;
    in_valid = 1'b0; key_config = 1'b1; tick;
    key_config = 1'b0;
    checks++; if ({rdy, keys_valid, comp_valid} !== 3'b011 || comp_data !== 64'hCC) begin errors++; $display("FAIL drain_entry got=%b/%h exp=011/cc", {rdy, keys_valid, comp_valid}, comp_data); end
    tick;
    checks++; if ({rdy, keys_valid, comp_valid} !== 3'b011) begin errors++; $display("FAIL drain_hold got=%b exp=011", {rdy, keys_valid, comp_valid}); end
    comp_ready = 1'b1; tick;
    comp_ready = 1'b0;
    checks++; if ({rdy, keys_valid, comp_valid, key_count} !== 5'b10000) begin errors++; $display("FAIL drain_to_load got=%b exp=10000", {rdy, keys_valid, comp_valid, key_count}); end
    checks++; if (key_out !== 192'b0) begin errors++; $display("FAIL drain_clear got=%h exp=0", key_out); end
    in_valid = 1'b1; data_in = K0; tick;
    data_in = K1; tick;
    checks++; if (key_count !== 2'd2) begin errors++; $display("FAIL partial_cnt got=%0d exp=2", key_count); end
    key_config = 1'b1; data_in = 64'hDEAD; tick;
    key_config = 1'b0;
    checks++; if (key_count !== 2'd0 || key_out !== 192'b0) begin errors++; $display("FAIL restart got=%0d/%h exp=0/0", key_count, key_out); end
    data_in = K2; tick;
    data_in = K1; tick;
    data_in = K0; tick;
    in_valid = 1'b0;
    checks++; if ({done, keys_valid} !== 2'b11 || key_out !== {K0, K1, K2}) begin errors++; $display("FAIL reload got=%b/%h exp=11/%h", {done, keys_valid}, key_out, {K0, K1, K2}); end
  endtask

  task automatic test_error;
    do_reset;
    in_valid = 1'b1; data_in = 64'h55; tick;
    checks++; if ({error, rdy, comp_valid} !== 3'b100) begin errors++; $display("FAIL err_set got=%b exp=100", {error, rdy, comp_valid}); end
    tick;
    checks++; if ({error, rdy, key_count} !== 4'b1000) begin errors++; $display("FAIL err_sticky got=%b exp=1000", {error, rdy, key_count}); end
    in_valid = 1'b0; key_config = 1'b1; tick;
    key_config = 1'b0;
    checks++; if ({error, rdy} !== 2'b01) begin errors++; $display("FAIL err_clear got=%b exp=01", {error, rdy}); end
    do_reset;
    key_config = 1'b1; in_valid = 1'b1; tick;
    key_config = 1'b0; in_valid = 1'b0;
    checks++; if ({error, rdy, key_count} !== 4'b0100) begin errors++; $display("FAIL cfg_wins got=%b exp=0100", {error, rdy, key_count}); end
  endtask

  task automatic test_reset_mid_run;
    do_reset;
    load_keys(K0, K1, K2);
    comp_ready = 1'b0; in_valid = 1'b1; data_in = 64'h77; tick;
    in_valid = 1'b0;
    checks++; if (comp_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got=%b exp=1", comp_valid); end
    rst = 1'b1; #1;
    checks++; if ({comp_valid, keys_valid, key_count} !== 4'b0 || key_out !== 192'b0 || comp_data !== 64'b0) begin errors++; $display("FAIL async_reset got=%b/%h/%h exp=0/0/0", {comp_valid, keys_valid, key_count}, key_out, comp_data); end
    tick;
    rst = 1'b0;
  endtask

  task automatic test_parity;
    do_reset;
`ifdef DSEC_KEY_PARITY_EN
    key_config = 1'b1; tick;
    key_config = 1'b0; in_valid = 1'b1; data_in = K0; tick;
    data_in = 64'h0; tick;
    in_valid = 1'b0;
    checks++; if ({error, keys_valid, done, rdy, key_count} !== 6'b100000) begin errors++; $display("FAIL parity_reject got=%b exp=100000", {error, keys_valid, done, rdy, key_count}); end
    checks++; if (key_out !== 192'b0) begin errors++; $display("FAIL parity_clear got=%h exp=0", key_out); end
    load_keys(64'h0101010101010101, 64'h0101010101010101, K0);
    checks++; if ({done, keys_valid, error} !== 3'b110) begin errors++; $display("FAIL parity_accept got=%b exp=110", {done, keys_valid, error}); end
`else
    load_keys(64'h0, 64'h0, 64'h0);
    checks++; if ({done, keys_valid, error} !== 3'b110) begin errors++; $display("FAIL noparity_accept got=%b exp=110", {done, keys_valid, error}); end
`endif
  endtask

  initial begin
    test_reset;
    test_load;
    test_stream;
    test_backpressure;
    test_rekey;
    test_error;
    test_reset_mid_run;
    test_parity;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
